// File: rtl/alu16_cmd_issuer.sv
// alu16_cmd_issuer: buffers ALU commands in a small FIFO, issues them one at a
// time to the combinational ALU, captures c/flags after a settle window and
// returns each result over a valid/ready handshake.
module alu16_cmd_issuer #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [5:0]                    cmd_op,
   input  logic [15:0]                   cmd_a,
   input  logic [15:0]                   cmd_b,
   output logic [15:0]                   alu_a,
   output logic [15:0]                   alu_b,
   output logic [5:0]                    alu_op,
   output logic                          alu_enable,
   input  logic [31:0]                   alu_c,
   input  logic [7:1]                    alu_flags,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [31:0]                   res_data,
   output logic [7:1]                    res_flags,
   output logic [5:0]                    res_op,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic [7:0]                    err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

   // FIFO entry layout: {op, a, b}
   logic [37:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [1:0]    state_q, state_d;
   logic [3:0]    settle_q, settle_d;
   logic [15:0]   alu_a_q, alu_a_d;
   logic [15:0]   alu_b_q, alu_b_d;
   logic [5:0]    alu_op_q, alu_op_d;
   logic          alu_en_q, alu_en_d;
   logic          res_valid_q, res_valid_d;
   logic [31:0]   res_data_q, res_data_d;
   logic [7:1]    res_flags_q, res_flags_d;
   logic [5:0]    res_op_q, res_op_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          flag_err;
   logic [37:0]   head;

   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == ST_IDLE) && !fifo_empty;
   assign head       = mem_q[rd_ptr_q];
   assign flag_err   = alu_flags[1] | alu_flags[2] | alu_flags[5] |
                       alu_flags[6] | alu_flags[7];

   // FIFO pointer and occupancy update; push and pop in one cycle cancel out
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Issue state machine: pop, drive for the settle window, hold the result
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_en_d    = alu_en_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_flags_d = res_flags_q;
      res_op_d    = res_op_q;
      err_cnt_d   = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            alu_en_d = 1'b0;
            if (!fifo_empty) begin
               alu_op_d = head[37:32];
               alu_a_d  = head[31:16];
               alu_b_d  = head[15:0];
               res_op_d = head[37:32];
               settle_d = 4'(SETTLE_CYCLES - 1);
               alu_en_d = 1'b1;
               state_d  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (settle_q != '0) begin
               settle_d = settle_q - 1'b1;
            end else begin
               res_data_d  = alu_c;
               res_flags_d = alu_flags;
               res_valid_d = 1'b1;
               alu_en_d    = 1'b0;
               if (flag_err && (err_cnt_q != '1)) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               state_d = ST_RESULT;
            end
         end
         ST_RESULT: begin
            alu_en_d = 1'b0;
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            alu_en_d    = 1'b0;
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         settle_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_flags_q <= '0;
         res_op_q    <= '0;
         err_cnt_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         settle_q    <= settle_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_en_q    <= alu_en_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_flags_q <= res_flags_d;
         res_op_q    <= res_op_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign alu_enable = alu_en_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_flags  = res_flags_q;
   assign res_op     = res_op_q;
   assign fifo_count = count_q;
   assign err_cnt    = err_cnt_q;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu16_cmd_issuer.sv
// Self-checking bench for alu16_cmd_issuer: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based reference.
module tb_alu16_cmd_issuer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance 1: SETTLE_CYCLES = 1 ----------------
   logic        rst_n, cmd_valid, cmd_ready, alu_enable, res_valid, res_ready, busy;
   logic [5:0]  cmd_op, alu_op, res_op;
   logic [15:0] cmd_a, cmd_b, alu_a, alu_b;
   logic [31:0] alu_c, res_data;
   logic [7:1]  alu_flags, res_flags;
   logic [2:0]  fifo_count;
   logic [7:0]  err_cnt;

   alu16_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
      .alu_c(alu_c), .alu_flags(alu_flags),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_flags(res_flags), .res_op(res_op), .fifo_count(fifo_count),
      .busy(busy), .err_cnt(err_cnt));

   // ---------------- instance 2: SETTLE_CYCLES = 3 ----------------
   logic        rst2_n, c2_valid, c2_ready, a2_en, r2_valid, r2_ready, busy2;
   logic [5:0]  c2_op, a2_op, r2_op;
   logic [15:0] c2_a, c2_b, a2_a, a2_b;
   logic [31:0] a2_c, r2_data;
   logic [7:1]  a2_flags, r2_flags;
   logic [2:0]  f2_count;
   logic [7:0]  err2;

   alu16_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst2_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_op(c2_op), .cmd_a(c2_a), .cmd_b(c2_b),
      .alu_a(a2_a), .alu_b(a2_b), .alu_op(a2_op), .alu_enable(a2_en),
      .alu_c(a2_c), .alu_flags(a2_flags),
      .res_valid(r2_valid), .res_ready(r2_ready), .res_data(r2_data),
      .res_flags(r2_flags), .res_op(r2_op), .fifo_count(f2_count),
      .busy(busy2), .err_cnt(err2));

   // ---------------- ALU stand-in (environment) ----------------
   // returns {flags[7:1], c}
   function automatic logic [38:0] alu_fn(input logic [5:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      logic [31:0] c;
      logic [7:1]  f;
      logic [16:0] s;
      logic [15:0] d;
      c = '0;
      f = '0;
      case (op)
         6'd1: begin
            s = {1'b0, a} + {1'b0, b};
            c = {15'd0, s};
            f[1] = (a[15] == b[15]) && (s[15] != a[15]);
            f[4] = s[16];
         end
         6'd2: begin
            d = a - b;
            c = {16'd0, d};
            f[1] = (a[15] != b[15]) && (d[15] != a[15]);
         end
         6'd3: c = {16'd0, a & b};
         6'd6: begin
            if (b == 16'd0) f[2] = 1'b1;
            else c = {16'd0, a / b};
         end
         default: c = {16'd0, a ^ b};
      endcase
      f[3] = (c == 32'd0);
      return {f, c};
   endfunction

   logic [15:0] stk [8];
   int          sp = 0;
   logic        en_prev = 1'b0;

   always_comb begin
      {alu_flags, alu_c} = alu_fn(alu_op, alu_a, alu_b);
      if (alu_op == 6'd29) begin
         alu_c     = {16'd0, alu_a};
         alu_flags = (alu_a == 16'd0) ? 7'h04 : 7'h00;
      end else if (alu_op == 6'd30) begin
         alu_c     = (sp > 0) ? {16'd0, stk[sp-1]} : 32'd0;
         alu_flags = (alu_c == 32'd0) ? 7'h04 : 7'h00;
      end
   end

   // stack ops take effect on the first clock of each enable pulse
   always_ff @(posedge clk) begin
      en_prev <= alu_enable;
      if (alu_enable && !en_prev) begin
         if (alu_op == 6'd29 && sp < 8) begin
            stk[sp] <= alu_a;
            sp      <= sp + 1;
         end else if (alu_op == 6'd30 && sp > 0) begin
            sp <= sp - 1;
         end
      end
   end

   always_comb {a2_flags, a2_c} = alu_fn(a2_op, a2_a, a2_b);

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard for instance 1 ----------------
   typedef struct {
      logic [5:0]  op;
      logic [31:0] c;
      logic [7:1]  f;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mstk[$];
   int          m_err = 0;
   bit          mon_en = 0;

   bit          gap_arm = 0;
   bit          seen_high, prev_high;
   int          low_run, min_gap, gaps;

   initial begin
      exp_t e;
      exp_t g;
      logic [38:0] r;
      forever begin
         @(negedge clk);
         if (mon_en && cmd_valid && cmd_ready) begin
            e.op = cmd_op;
            if (cmd_op == 6'd29) begin
               e.c = {16'd0, cmd_a};
               mstk.push_back(cmd_a);
            end else if (cmd_op == 6'd30) begin
               e.c = (mstk.size() > 0) ? {16'd0, mstk.pop_back()} : 32'd0;
            end else begin
               r   = alu_fn(cmd_op, cmd_a, cmd_b);
               e.c = r[31:0];
            end
            if (cmd_op == 6'd29 || cmd_op == 6'd30) e.f = (e.c == 0) ? 7'h04 : 7'h00;
            else e.f = r[38:32];
            exp_q.push_back(e);
         end
         if (mon_en && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               g = exp_q.pop_front();
               if (g.f[1] | g.f[2] | g.f[5] | g.f[6] | g.f[7])
                  m_err = (m_err < 255) ? m_err + 1 : 255;
               chk("sb_data", res_data, g.c);
               chk("sb_flags", {25'd0, res_flags}, {25'd0, g.f});
               chk("sb_op", {26'd0, res_op}, {26'd0, g.op});
               chk("sb_err_cnt", {24'd0, err_cnt}, m_err);
            end
         end
         if (gap_arm) begin
            if (alu_enable) begin
               if (seen_high && !prev_high) begin
                  gaps++;
                  if (low_run < min_gap) min_gap = low_run;
               end
               seen_high = 1;
               low_run   = 0;
            end else begin
               low_run++;
            end
            prev_high = alu_enable;
         end
      end
   end

   task automatic push_cmd(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int budget, output bit ok);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk); #1;
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      bit done;
      done = 0;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !busy && !res_valid) begin
            done = 1;
            break;
         end
      end
      chk(name, {31'd0, done}, 32'd1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [5:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_c;
      logic [7:1]  exp_f;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t vt[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int acc;
      vt[0] = '{6'd1, 16'h0003, 16'h0005, 32'h0000_0008, 7'h00, 8'd0};
      vt[1] = '{6'd6, 16'h0004, 16'h0000, 32'h0000_0000, 7'h06, 8'd1};
      vt[2] = '{6'd6, 16'h0004, 16'h0002, 32'h0000_0002, 7'h00, 8'd1};
      vt[3] = '{6'd1, 16'h7FFF, 16'h0001, 32'h0000_8000, 7'h01, 8'd2};
      vt[4] = '{6'd1, 16'hFFFF, 16'h0001, 32'h0001_0000, 7'h08, 8'd2};
      vt[5] = '{6'd2, 16'h0005, 16'h0005, 32'h0000_0000, 7'h04, 8'd2};
      vt[6] = '{6'd3, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 7'h00, 8'd2};
      vt[7] = '{6'd6, 16'h0007, 16'h0002, 32'h0000_0003, 7'h00, 8'd2};

      rst_n = 0; cmd_valid = 0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 0;
      rst2_n = 0; c2_valid = 0; c2_op = '0; c2_a = '0; c2_b = '0; r2_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_alu_enable", {31'd0, alu_enable}, 0);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_fifo_count", {29'd0, fifo_count}, 0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_res_data", res_data, 0);
      chk("rst_alu_a", {16'd0, alu_a}, 0);
      rst_n = 1; rst2_n = 1;
      res_ready = 1;
      @(posedge clk); #1;

      // table: each command into an idle, empty issuer with res_ready=1
      for (int i = 0; i < 8; i++) begin
         cmd_op = vt[i].op; cmd_a = vt[i].a; cmd_b = vt[i].b; cmd_valid = 1;
         @(posedge clk); #1;              // accept edge N
         cmd_valid = 0;
         chk("tv_en_n", {31'd0, alu_enable}, 0);
         @(posedge clk); #1;              // N+1: driving
         chk("tv_en_n1", {31'd0, alu_enable}, 1);
         chk("tv_valid_n1", {31'd0, res_valid}, 0);
         chk("tv_alu_a", {16'd0, alu_a}, {16'd0, vt[i].a});
         @(posedge clk); #1;              // N+2: result
         chk("tv_en_n2", {31'd0, alu_enable}, 0);
         chk("tv_valid_n2", {31'd0, res_valid}, 1);
         chk("tv_data", res_data, vt[i].exp_c);
         chk("tv_flags", {25'd0, res_flags}, {25'd0, vt[i].exp_f});
         chk("tv_op", {26'd0, res_op}, {26'd0, vt[i].op});
         chk("tv_err", {24'd0, err_cnt}, {24'd0, vt[i].exp_err});
         @(posedge clk); #1;              // N+3: consumed
         chk("tv_valid_n3", {31'd0, res_valid}, 0);
         chk("tv_alu_a_hold", {16'd0, alu_a}, {16'd0, vt[i].a});
      end
      m_err = 2;
      mon_en = 1;

      // backpressure: 5 accepted, 6th stalls
      res_ready = 0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         push_cmd(6'd1, 16'(i * 100), 16'(i), 8, ok);
         if (ok) acc++;
      end
      chk("bp_accepted", acc, 5);
      push_cmd(6'd2, 16'h0050, 16'h0001, 6, ok);
      chk("bp_sixth_stall", {31'd0, ok}, 0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 0);
      chk("bp_fifo_count", {29'd0, fifo_count}, 4);
      chk("bp_busy", {31'd0, busy}, 1);
      drain("bp_drain");

      // repeated push / pop with identical operands, gap on enable
      seen_high = 0; prev_high = 0; low_run = 0; min_gap = 1000; gaps = 0;
      gap_arm = 1;
      push_cmd(6'd29, 16'h1234, 16'h0000, 16, ok); chk("rp_push0", {31'd0, ok}, 1);
      push_cmd(6'd29, 16'h1234, 16'h0000, 16, ok); chk("rp_push1", {31'd0, ok}, 1);
      push_cmd(6'd30, 16'h0000, 16'h0000, 16, ok); chk("rp_pop0", {31'd0, ok}, 1);
      push_cmd(6'd30, 16'h0000, 16'h0000, 16, ok); chk("rp_pop1", {31'd0, ok}, 1);
      drain("rp_drain");
      gap_arm = 0;
      chk("rp_gap_count", gaps, 3);
      chk("rp_min_gap_ge2", {31'd0, (min_gap >= 2)}, 1);

      // instance 2: SETTLE_CYCLES=3 latency, then reset mid-DRIVE
      c2_op = 6'd6; c2_a = 16'h0004; c2_b = 16'h0000; c2_valid = 1;
      @(posedge clk); #1;
      c2_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k < 4) begin
            chk("s3_en_high", {31'd0, a2_en}, 1);
            chk("s3_valid_low", {31'd0, r2_valid}, 0);
         end else begin
            chk("s3_en_low", {31'd0, a2_en}, 0);
            chk("s3_valid", {31'd0, r2_valid}, 1);
            chk("s3_flags", {25'd0, r2_flags}, 32'h06);
            chk("s3_err", {24'd0, err2}, 1);
         end
      end
      @(posedge clk); #1;
      c2_op = 6'd1; c2_a = 16'd1; c2_b = 16'd2; c2_valid = 1;
      @(posedge clk); #1;                 // M
      c2_a = 16'd3; c2_b = 16'd3;
      @(posedge clk); #1;                 // M+1: first cmd in DRIVE
      c2_valid = 0;
      @(posedge clk); #1;                 // M+2: second DRIVE cycle
      chk("mr_en_before", {31'd0, a2_en}, 1);
      chk("mr_count_before", {29'd0, f2_count}, 1);
      rst2_n = 0;
      @(posedge clk); #1;                 // M+3: reset taken
      chk("mr_en", {31'd0, a2_en}, 0);
      chk("mr_valid", {31'd0, r2_valid}, 0);
      chk("mr_count", {29'd0, f2_count}, 0);
      chk("mr_err", {24'd0, err2}, 0);
      chk("mr_busy", {31'd0, busy2}, 0);
      rst2_n = 1;
      begin
         bit seen;
         seen = 0;
         for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (r2_valid || a2_en) seen = 1;
         end
         chk("mr_no_result", {31'd0, seen}, 0);
      end

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         logic [5:0] ops [5];
         ops[0] = 6'd1; ops[1] = 6'd2; ops[2] = 6'd3; ops[3] = 6'd6; ops[4] = 6'd9;
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_op    = ops[$urandom_range(0, 4)];
         cmd_a     = 16'($urandom);
         cmd_b     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain("rand_drain");

      // error counter saturation
      for (int i = 0; i < 260; i++) begin
         push_cmd(6'd6, 16'($urandom), 16'd0, 32, ok);
         if (!ok) chk("sat_push", 0, 1);
      end
      drain("sat_drain");
      chk("sat_err_cnt", {24'd0, err_cnt}, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu16_cmd_issuer.md
Name: alu16_cmd_issuer

Overview:
Sequential initiator for the 16-bit combinational ALU. It buffers opcode/operand commands from an upstream controller, drives them onto the ALU's a/b/op/enable inputs one at a time, and captures the ALU's c and flags after a settle window. It returns each result over a valid/ready handshake. It sits between any command source (test sequencer, microcode engine) and the ALU instance.

Parameters:
FIFO_DEPTH, 4, number of command entries buffered; must be a power of 2, at least 2.
SETTLE_CYCLES, 1, cycles alu_enable is held high before alu_c/alu_flags are sampled; range 1–15.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  issuer can accept a command.
cmd_op  input  6  ALU opcode.
cmd_a  input  16  operand a.
cmd_b  input  16  operand b.
alu_a  output  16  drives ALU input a.
alu_b  output  16  drives ALU input b.
alu_op  output  6  drives ALU input op.
alu_enable  output  1  drives ALU input enable.
alu_c  input  32  ALU result.
alu_flags  input  7  ALU flags: [1] ovf, [2] div0, [3] zero, [4] carry, [5] stk ovf, [6] stk unf, [7] cnt exceed.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_data  output  32  captured alu_c.
res_flags  output  7  captured alu_flags.
res_op  output  6  opcode that produced the result.
fifo_count  output  $clog2(FIFO_DEPTH)+1  commands currently buffered.
busy  output  1  high when the state machine is not in IDLE, or when the FIFO is not empty.
err_cnt  output  8  saturating count of results with res_flags[1], [2], [5], [6] or [7] set.

Behaviour:
- Reset (rst_n=0 at an edge): all of the following are forced to 0: FIFO pointers, fifo_count, state (IDLE), alu_a, alu_b, alu_op, alu_enable, res_valid, res_data, res_flags, res_op, err_cnt, settle counter. Reset applies mid-operation and aborts any command in flight; no result is emitted for it.
- cmd_ready = (fifo_count != FIFO_DEPTH). It does not depend on a same-cycle pop, so there is no full-bypass path.
- FIFO write on cmd_valid && cmd_ready. There is no empty-bypass: a command written at edge N is visible to the state machine at cycle N+1.
- FSM states:
  - IDLE: alu_enable=0. If the FIFO is not empty, pop the head into alu_a/alu_b/alu_op and the res_op shadow, load settle counter = SETTLE_CYCLES-1, and go to DRIVE.
  - DRIVE: alu_enable=1; operands held stable. While counter != 0, decrement. When counter == 0, latch res_data<=alu_c and res_flags<=alu_flags, set res_valid=1, update err_cnt, and go to RESULT.
  - RESULT: alu_enable=0; res_valid=1; res_* held stable. On res_ready go to IDLE with res_valid<=0.
- Latency: a command accepted at edge N into an empty, idle issuer gives res_valid=1 after edge N+1+SETTLE_CYCLES.
- alu_enable is low for at least 2 cycles (RESULT, IDLE) between consecutive commands. This guarantees the ALU re-evaluates identical back-to-back commands, e.g. two pushes with the same a.
- alu_a/alu_b/alu_op hold their last values outside DRIVE; only alu_enable drops.
- Capacity: FIFO_DEPTH buffered plus 1 in flight. With FIFO_DEPTH=4 and res_ready=0, 5 commands are accepted and the 6th stalls.
- Simultaneous FIFO write and pop in the same cycle: fifo_count is unchanged; both take effect.
- err_cnt saturates at 255 and does not wrap. err_cnt is not reset by anything except rst_n.
- res_flags reports the ALU's flags verbatim. Carry (flag[4]) persistence is the ALU's concern; the issuer neither clears nor modifies it.
- busy=0 only in IDLE with the FIFO empty.

Test Plan:
- Single add, op=1, a=3, b=5, res_ready=1, command accepted at edge 0 -> alu_enable high for exactly 1 cycle; res_valid after edge 2; res_data=8, res_flags[3]=0, res_op=1.
- Divide by zero, op=6, a=4, b=0 -> res_flags[2]=1, res_data=0, err_cnt=1. Follow with op=6, a=4, b=2 -> res_data=2, err_cnt stays at 1.
- Backpressure: res_ready=0, offer 6 commands back to back -> 5 accepted, cmd_ready=0 with fifo_count=4. Release res_ready -> results return in order with matching res_op.
- Repeated push: op=29, a=0x1234 twice, then op=30 twice -> two pops return 0x1234 both times. alu_enable shows a low gap of at least 2 cycles between commands.
- Reset mid-DRIVE with SETTLE_CYCLES=3: assert rst_n=0 in the 2nd DRIVE cycle -> at the next edge alu_enable=0, res_valid=0, fifo_count=0, err_cnt=0; no result is emitted.
- Saturation: 260 commands of op=6, b=0 -> err_cnt=255.
